instr_decode_stage_rv: RTL and testbench

//  Registered RV32I(+M) decode stage between fetch and execute. Decodes one instruction per cycle into the

---
 rtl/instr_decode_stage_rv_pkg.sv | 111 +++++++++++
 rtl/instr_decode_stage_rv_ctrl.sv | 143 ++++++++++++++
 rtl/instr_decode_stage_rv.sv | 126 ++++++++++++
 tb/tb_instr_decode_stage_rv.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_decode_stage_rv_pkg.sv
// Shared encodings, control-bundle payload and decode helpers for the RV32I(+M) decode stage.
package instr_decode_stage_rv_pkg;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned ALU_OP_W  = 6;
   localparam int unsigned EXC_W     = 4;
   localparam int unsigned REG_IDX_W = 5;

   // Major opcodes
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   localparam logic [XLEN-1:0] INSTR_ECALL  = 32'h0000_0073;
   localparam logic [XLEN-1:0] INSTR_EBREAK = 32'h0010_0073;

   // ALU operations; MUL..REMU follow funct3 order so MUL + funct3 selects the op
   localparam logic [ALU_OP_W-1:0] ALU_OP_ADD    = 6'd0;
   localparam logic [ALU_OP_W-1:0] ALU_OP_SUB    = 6'd1;
   localparam logic [ALU_OP_W-1:0] ALU_OP_SLL    = 6'd2;
   localparam logic [ALU_OP_W-1:0] ALU_OP_SLT    = 6'd3;
   localparam logic [ALU_OP_W-1:0] ALU_OP_SLTU   = 6'd4;
   localparam logic [ALU_OP_W-1:0] ALU_OP_XOR    = 6'd5;
   localparam logic [ALU_OP_W-1:0] ALU_OP_SRL    = 6'd6;
   localparam logic [ALU_OP_W-1:0] ALU_OP_SRA    = 6'd7;
   localparam logic [ALU_OP_W-1:0] ALU_OP_OR     = 6'd8;
   localparam logic [ALU_OP_W-1:0] ALU_OP_AND    = 6'd9;
   localparam logic [ALU_OP_W-1:0] ALU_OP_SEQ    = 6'd10;
   localparam logic [ALU_OP_W-1:0] ALU_OP_MUL    = 6'd16;
   localparam logic [ALU_OP_W-1:0] ALU_OP_MULH   = 6'd17;
   localparam logic [ALU_OP_W-1:0] ALU_OP_MULHSU = 6'd18;
   localparam logic [ALU_OP_W-1:0] ALU_OP_MULHU  = 6'd19;
   localparam logic [ALU_OP_W-1:0] ALU_OP_DIV    = 6'd20;
   localparam logic [ALU_OP_W-1:0] ALU_OP_DIVU   = 6'd21;
   localparam logic [ALU_OP_W-1:0] ALU_OP_REM    = 6'd22;
   localparam logic [ALU_OP_W-1:0] ALU_OP_REMU   = 6'd23;

   localparam logic ALU_B_SOURCE_IMMEDIATE = 1'b0;
   localparam logic ALU_B_SOURCE_REG       = 1'b1;

   localparam logic [1:0] REG_SOURCE_ALU       = 2'd0;
   localparam logic [1:0] REG_SOURCE_MEMORY    = 2'd1;
   localparam logic [1:0] REG_SOURCE_IMMEDIATE = 2'd2;

   localparam logic [1:0] MEM_ACCESS_NONE      = 2'd0;
   localparam logic [1:0] MEM_ACCESS_BYTE      = 2'd1;
   localparam logic [1:0] MEM_ACCESS_HALF_WORD = 2'd2;
   localparam logic [1:0] MEM_ACCESS_WORD      = 2'd3;

   localparam logic [1:0] NEXT_PC_SRC_SEQ  = 2'd0;
   localparam logic [1:0] NEXT_PC_SRC_JAL  = 2'd1;
   localparam logic [1:0] NEXT_PC_SRC_JALR = 2'd2;
   localparam logic [1:0] NEXT_PC_SRC_B    = 2'd3;

   localparam logic [EXC_W-1:0] EXCEPTION_SUCCESS       = 4'd0;
   localparam logic [EXC_W-1:0] EXCEPTION_ILLEGAL_INSTR = 4'd1;
   localparam logic [EXC_W-1:0] EXCEPTION_ECALL         = 4'd2;
   localparam logic [EXC_W-1:0] EXCEPTION_BREAK         = 4'd3;

   // Execute control bundle
   typedef struct packed {
      logic [XLEN-1:0]      pc;
      logic [ALU_OP_W-1:0]  alu_op;
      logic                 alu_b_src;
      logic [XLEN-1:0]      alu_b_imm;
      logic                 branch_inv;
      logic [REG_IDX_W-1:0] rs1;
      logic [REG_IDX_W-1:0] rs2;
      logic [REG_IDX_W-1:0] rd;
      logic [1:0]           wr_src;
      logic [XLEN-1:0]      wr_imm;
      logic                 dmem_write;
      logic                 dmem_sext;
      logic [1:0]           dmem_access;
      logic [1:0]           next_pc_src;
      logic [19:0]          imm20;
      logic [11:0]          imm12;
      logic [EXC_W-1:0]     exception;
   } dec_ctrl_t;

   function automatic logic [XLEN-1:0] sign_extend_12_32(input logic [11:0] imm);
      return {{20{imm[11]}}, imm};
   endfunction

   // Base-variant ALU op for OP / OP_IMM funct3
   function automatic logic [ALU_OP_W-1:0] alu_op_base(input logic [2:0] f3);
      case (f3)
         3'd0:    return ALU_OP_ADD;
         3'd1:    return ALU_OP_SLL;
         3'd2:    return ALU_OP_SLT;
         3'd3:    return ALU_OP_SLTU;
         3'd4:    return ALU_OP_XOR;
         3'd5:    return ALU_OP_SRL;
         3'd6:    return ALU_OP_OR;
         default: return ALU_OP_AND;
      endcase
   endfunction

endpackage

// File: rtl/instr_decode_stage_rv_ctrl.sv
// Combinational decode of one instruction word + PC into the execute control bundle.
//  i_instr   instruction word
//  i_pc      address of i_instr
//  o_ctrl_c  decoded control bundle (combinational)
module instr_ctrl_rv
   import instr_decode_stage_rv_pkg::*;
#(
   parameter int unsigned ENABLE_M      = 1,
   parameter int unsigned ENABLE_SYSTEM = 1
) (
   input  logic [XLEN-1:0] i_instr,
   input  logic [XLEN-1:0] i_pc,
   output dec_ctrl_t       o_ctrl_c
);

   logic [6:0]      w_opcode;
   logic [2:0]      w_f3;
   logic [6:0]      w_f7;
   logic [4:0]      w_rd;
   logic [XLEN-1:0] w_imm_i;
   logic [XLEN-1:0] w_imm_s;
   logic [XLEN-1:0] w_pc_plus4;
   dec_ctrl_t       w_ctrl;

   assign w_opcode   = i_instr[6:0];
   assign w_f3       = i_instr[14:12];
   assign w_f7       = i_instr[31:25];
   assign w_rd       = i_instr[11:7];
   assign w_imm_i    = sign_extend_12_32(i_instr[31:20]);
   assign w_imm_s    = sign_extend_12_32({i_instr[31:25], i_instr[11:7]});
   assign w_pc_plus4 = i_pc + 32'd4;

   // Per-opcode decode, then scrub side-effecting controls for any exception
   always_comb begin
      w_ctrl             = '0;
      w_ctrl.pc          = i_pc;
      w_ctrl.alu_op      = ALU_OP_ADD;
      w_ctrl.alu_b_src   = ALU_B_SOURCE_IMMEDIATE;
      w_ctrl.rs1         = i_instr[19:15];
      w_ctrl.rs2         = i_instr[24:20];
      w_ctrl.wr_src      = REG_SOURCE_ALU;
      w_ctrl.next_pc_src = NEXT_PC_SRC_SEQ;
      w_ctrl.imm20       = i_instr[31:12];
      w_ctrl.imm12       = i_instr[31:20];
      w_ctrl.exception   = EXCEPTION_SUCCESS;

      case (w_opcode)
         OPC_LUI, OPC_AUIPC: begin
            w_ctrl.rd     = w_rd;
            w_ctrl.wr_src = REG_SOURCE_IMMEDIATE;
            w_ctrl.wr_imm = {i_instr[31:12], 12'h000} + ((w_opcode == OPC_AUIPC) ? i_pc : 32'd0);
         end
         OPC_JAL, OPC_JALR: begin
            w_ctrl.rd          = w_rd;
            w_ctrl.wr_src      = REG_SOURCE_IMMEDIATE;
            w_ctrl.wr_imm      = w_pc_plus4;
            w_ctrl.next_pc_src = (w_opcode == OPC_JAL) ? NEXT_PC_SRC_JAL : NEXT_PC_SRC_JALR;
            if (w_opcode == OPC_JALR && w_f3 != 3'd0) w_ctrl.exception = EXCEPTION_ILLEGAL_INSTR;
         end
         OPC_BRANCH: begin
            // funct3 bit0 selects the inverted compare (BNE/BGE/BGEU)
            w_ctrl.alu_b_src   = ALU_B_SOURCE_REG;
            w_ctrl.next_pc_src = NEXT_PC_SRC_B;
            w_ctrl.branch_inv  = w_f3[0];
            w_ctrl.alu_op      = w_f3[2] ? (w_f3[1] ? ALU_OP_SLTU : ALU_OP_SLT) : ALU_OP_SEQ;
            w_ctrl.imm12       = {i_instr[31:25], i_instr[11:7]};
            if (w_f3[2:1] == 2'b01) w_ctrl.exception = EXCEPTION_ILLEGAL_INSTR;
         end
         OPC_LOAD: begin
            w_ctrl.rd          = w_rd;
            w_ctrl.wr_src      = REG_SOURCE_MEMORY;
            w_ctrl.alu_b_imm   = w_imm_i;
            w_ctrl.dmem_access = w_f3[1] ? MEM_ACCESS_WORD :
                                 (w_f3[0] ? MEM_ACCESS_HALF_WORD : MEM_ACCESS_BYTE);
            w_ctrl.dmem_sext   = !w_f3[2] && !w_f3[1];
            if (w_f3[1:0] == 2'b11 || (w_f3[2] && w_f3[1])) w_ctrl.exception = EXCEPTION_ILLEGAL_INSTR;
         end
         OPC_STORE: begin
            w_ctrl.dmem_write  = 1'b1;
            w_ctrl.alu_b_imm   = w_imm_s;
            w_ctrl.dmem_access = w_f3[1] ? MEM_ACCESS_WORD :
                                 (w_f3[0] ? MEM_ACCESS_HALF_WORD : MEM_ACCESS_BYTE);
            if (w_f3 > 3'd2) w_ctrl.exception = EXCEPTION_ILLEGAL_INSTR;
         end
         OPC_OP_IMM: begin
            w_ctrl.rd        = w_rd;
            w_ctrl.alu_b_imm = w_imm_i;
            w_ctrl.alu_op    = alu_op_base(w_f3);
            // Shift-immediates carry funct7 in the upper immediate bits
            if (w_f3 == 3'd1 && w_f7 != F7_BASE) w_ctrl.exception = EXCEPTION_ILLEGAL_INSTR;
            if (w_f3 == 3'd5) begin
               if (w_f7 == F7_ALT)       w_ctrl.alu_op    = ALU_OP_SRA;
               else if (w_f7 != F7_BASE) w_ctrl.exception = EXCEPTION_ILLEGAL_INSTR;
            end
         end
         OPC_OP: begin
            w_ctrl.rd        = w_rd;
            w_ctrl.alu_b_src = ALU_B_SOURCE_REG;
            case (w_f7)
               F7_BASE: w_ctrl.alu_op = alu_op_base(w_f3);
               F7_ALT: begin
                  if (w_f3 == 3'd0)      w_ctrl.alu_op    = ALU_OP_SUB;
                  else if (w_f3 == 3'd5) w_ctrl.alu_op    = ALU_OP_SRA;
                  else                   w_ctrl.exception = EXCEPTION_ILLEGAL_INSTR;
               end
               F7_MULDIV: begin
                  if (ENABLE_M != 0) w_ctrl.alu_op    = ALU_OP_MUL + 6'(w_f3);
                  else               w_ctrl.exception = EXCEPTION_ILLEGAL_INSTR;
               end
               default: w_ctrl.exception = EXCEPTION_ILLEGAL_INSTR;
            endcase
         end
         OPC_MISC_MEM: begin
            // FENCE retires as a no-op
            if (w_f3 != 3'd0) w_ctrl.exception = EXCEPTION_ILLEGAL_INSTR;
         end
         OPC_SYSTEM: begin
            if (ENABLE_SYSTEM == 0)          w_ctrl.exception = EXCEPTION_ILLEGAL_INSTR;
            else if (i_instr == INSTR_ECALL)  w_ctrl.exception = EXCEPTION_ECALL;
            else if (i_instr == INSTR_EBREAK) w_ctrl.exception = EXCEPTION_BREAK;
            else                             w_ctrl.exception = EXCEPTION_ILLEGAL_INSTR;
         end
         default: w_ctrl.exception = EXCEPTION_ILLEGAL_INSTR;
      endcase

      if (w_ctrl.exception != EXCEPTION_SUCCESS) begin
         w_ctrl.alu_op      = ALU_OP_ADD;
         w_ctrl.alu_b_src   = ALU_B_SOURCE_IMMEDIATE;
         w_ctrl.alu_b_imm   = '0;
         w_ctrl.branch_inv  = 1'b0;
         w_ctrl.rd          = '0;
         w_ctrl.wr_src      = REG_SOURCE_ALU;
         w_ctrl.wr_imm      = '0;
         w_ctrl.dmem_write  = 1'b0;
         w_ctrl.dmem_sext   = 1'b0;
         w_ctrl.dmem_access = MEM_ACCESS_NONE;
         w_ctrl.next_pc_src = NEXT_PC_SRC_SEQ;
      end
   end

   assign o_ctrl_c = w_ctrl;

endmodule

// File: rtl/instr_decode_stage_rv.sv
// Registered RV32I(+M) decode stage: valid/ready on both sides, 2-entry (output + skid) buffering,
// flush, and a saturating count of illegal instructions handed to execute.
//  iwClk/iwnRst              clock, async active-low reset
//  iwFlush                   drop everything buffered and the same-cycle input
//  iwInValid/owInReady       fetch handshake carrying iwInstr/iwPc
//  owOutValid/iwOutReady     execute handshake carrying the or* control bundle
//  orIllegalCount            saturating count of ILLEGAL_INSTR transfers
module instr_decode_stage_rv
   import instr_decode_stage_rv_pkg::*;
#(
   parameter int unsigned ENABLE_M      = 1,
   parameter int unsigned ENABLE_SYSTEM = 1,
   parameter int unsigned ILL_CNT_W     = 16
) (
   input  logic                 iwClk,
   input  logic                 iwnRst,
   input  logic                 iwFlush,
   input  logic                 iwInValid,
   output logic                 owInReady,
   input  logic [XLEN-1:0]      iwInstr,
   input  logic [XLEN-1:0]      iwPc,
   output logic                 owOutValid,
   input  logic                 iwOutReady,
   output logic [XLEN-1:0]      orPc,
   output logic [ALU_OP_W-1:0]  orAluOp,
   output logic                 orAluBSrc,
   output logic [XLEN-1:0]      orAluBImmediate,
   output logic                 orBranchInverted,
   output logic [REG_IDX_W-1:0] orReadReg1,
   output logic [REG_IDX_W-1:0] orReadReg2,
   output logic [REG_IDX_W-1:0] orWriteReg,
   output logic [1:0]           orWriteRegSource,
   output logic [XLEN-1:0]      orWriteRegImmediate,
   output logic                 orDMemWrite,
   output logic                 orDMemSignExtend,
   output logic [1:0]           orDMemAccess,
   output logic [1:0]           orNextPcSrc,
   output logic [19:0]          orNextPcImmediate20,
   output logic [11:0]          orNextPcImmediate12,
   output logic [EXC_W-1:0]     orException,
   output logic [ILL_CNT_W-1:0] orIllegalCount
);

   dec_ctrl_t            w_dec;
   dec_ctrl_t            r_out;
   dec_ctrl_t            r_skid;
   logic                 r_out_valid;
   logic                 r_skid_valid;
   logic [ILL_CNT_W-1:0] r_ill_cnt;
   logic                 w_in_fire;
   logic                 w_out_fire;
   logic                 w_out_free;

   instr_ctrl_rv #(
      .ENABLE_M      (ENABLE_M),
      .ENABLE_SYSTEM (ENABLE_SYSTEM)
   ) u_ctrl (
      .i_instr  (iwInstr),
      .i_pc     (iwPc),
      .o_ctrl_c (w_dec)
   );

   // Ready depends only on skid occupancy, so iwOutReady never reaches owInReady combinationally
   assign owInReady  = !r_skid_valid;
   assign w_in_fire  = iwInValid && owInReady;
   assign w_out_fire = r_out_valid && iwOutReady;
   assign w_out_free = !r_out_valid || iwOutReady;

   // Output/skid buffering; skid drains first so order is preserved
   always_ff @(posedge iwClk or negedge iwnRst) begin
      if (!iwnRst) begin
         r_out        <= '0;
         r_out_valid  <= 1'b0;
         r_skid       <= '0;
         r_skid_valid <= 1'b0;
      end else if (iwFlush) begin
         r_out_valid  <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (w_out_free) begin
         if (r_skid_valid) begin
            r_out        <= r_skid;
            r_out_valid  <= 1'b1;
            r_skid_valid <= 1'b0;
         end else if (w_in_fire) begin
            r_out       <= w_dec;
            r_out_valid <= 1'b1;
         end else begin
            r_out_valid <= 1'b0;
         end
      end else if (w_in_fire) begin
         r_skid       <= w_dec;
         r_skid_valid <= 1'b1;
      end
   end

   // Saturating illegal-instruction counter; a flush cycle discards the entry, so it is not counted
   always_ff @(posedge iwClk or negedge iwnRst) begin
      if (!iwnRst) begin
         r_ill_cnt <= '0;
      end else if (!iwFlush && w_out_fire && r_out.exception == EXCEPTION_ILLEGAL_INSTR &&
                   r_ill_cnt != {ILL_CNT_W{1'b1}}) begin
         r_ill_cnt <= r_ill_cnt + ILL_CNT_W'(1);
      end
   end

   assign owOutValid          = r_out_valid;
   assign orPc                = r_out.pc;
   assign orAluOp             = r_out.alu_op;
   assign orAluBSrc           = r_out.alu_b_src;
   assign orAluBImmediate     = r_out.alu_b_imm;
   assign orBranchInverted    = r_out.branch_inv;
   assign orReadReg1          = r_out.rs1;
   assign orReadReg2          = r_out.rs2;
   assign orWriteReg          = r_out.rd;
   assign orWriteRegSource    = r_out.wr_src;
   assign orWriteRegImmediate = r_out.wr_imm;
   assign orDMemWrite         = r_out.dmem_write;
   assign orDMemSignExtend    = r_out.dmem_sext;
   assign orDMemAccess        = r_out.dmem_access;
   assign orNextPcSrc         = r_out.next_pc_src;
   assign orNextPcImmediate20 = r_out.imm20;
   assign orNextPcImmediate12 = r_out.imm12;
   assign orException         = r_out.exception;
   assign orIllegalCount      = r_ill_cnt;

endmodule

// File: tb/tb_instr_decode_stage_rv.sv
// Directed bench for instr_decode_stage_rv: one instance with M enabled (16-bit counter) and one
// with M disabled and a 2-bit counter, both driven by the same stimulus.
module tb_instr_decode_stage_rv;

   logic        iwClk;
   logic        iwnRst;
   logic        iwFlush;
   logic        iwInValid;
   logic [31:0] iwInstr;
   logic [31:0] iwPc;
   logic        iwOutReady;

   // M-enabled instance outputs
   logic        m_in_ready, m_valid, m_bsrc, m_binv, m_dwr, m_sext;
   logic [31:0] m_pc, m_bimm, m_wimm;
   logic [5:0]  m_alu;
   logic [4:0]  m_rs1, m_rs2, m_rd;
   logic [1:0]  m_wsrc, m_acc, m_npc;
   logic [19:0] m_imm20;
   logic [11:0] m_imm12;
   logic [3:0]  m_exc;
   logic [15:0] m_cnt;

   // M-disabled instance outputs
   logic        n_in_ready, n_valid, n_bsrc, n_binv, n_dwr, n_sext;
   logic [31:0] n_pc, n_bimm, n_wimm;
   logic [5:0]  n_alu;
   logic [4:0]  n_rs1, n_rs2, n_rd;
   logic [1:0]  n_wsrc, n_acc, n_npc;
   logic [19:0] n_imm20;
   logic [11:0] n_imm12;
   logic [3:0]  n_exc;
   logic [1:0]  n_cnt;

   int n_vec;
   int n_miss;

   instr_decode_stage_rv #(.ENABLE_M(1), .ENABLE_SYSTEM(1), .ILL_CNT_W(16)) u_dut_m (
      .iwClk(iwClk), .iwnRst(iwnRst), .iwFlush(iwFlush), .iwInValid(iwInValid),
      .owInReady(m_in_ready), .iwInstr(iwInstr), .iwPc(iwPc), .owOutValid(m_valid),
      .iwOutReady(iwOutReady), .orPc(m_pc), .orAluOp(m_alu), .orAluBSrc(m_bsrc),
      .orAluBImmediate(m_bimm), .orBranchInverted(m_binv), .orReadReg1(m_rs1),
      .orReadReg2(m_rs2), .orWriteReg(m_rd), .orWriteRegSource(m_wsrc),
      .orWriteRegImmediate(m_wimm), .orDMemWrite(m_dwr), .orDMemSignExtend(m_sext),
      .orDMemAccess(m_acc), .orNextPcSrc(m_npc), .orNextPcImmediate20(m_imm20),
      .orNextPcImmediate12(m_imm12), .orException(m_exc), .orIllegalCount(m_cnt)
   );

   instr_decode_stage_rv #(.ENABLE_M(0), .ENABLE_SYSTEM(1), .ILL_CNT_W(2)) u_dut_nom (
      .iwClk(iwClk), .iwnRst(iwnRst), .iwFlush(iwFlush), .iwInValid(iwInValid),
      .owInReady(n_in_ready), .iwInstr(iwInstr), .iwPc(iwPc), .owOutValid(n_valid),
      .iwOutReady(iwOutReady), .orPc(n_pc), .orAluOp(n_alu), .orAluBSrc(n_bsrc),
      .orAluBImmediate(n_bimm), .orBranchInverted(n_binv), .orReadReg1(n_rs1),
      .orReadReg2(n_rs2), .orWriteReg(n_rd), .orWriteRegSource(n_wsrc),
      .orWriteRegImmediate(n_wimm), .orDMemWrite(n_dwr), .orDMemSignExtend(n_sext),
      .orDMemAccess(n_acc), .orNextPcSrc(n_npc), .orNextPcImmediate20(n_imm20),
      .orNextPcImmediate12(n_imm12), .orException(n_exc), .orIllegalCount(n_cnt)
   );

   initial iwClk = 1'b0;
   always #5 iwClk = ~iwClk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present one instruction for one cycle; on return the stage has captured it (if ready)
   task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
      iwInValid = 1'b1;
      iwInstr   = instr;
      iwPc      = pc;
      @(negedge iwClk);
      iwInValid = 1'b0;
   endtask

   initial begin
      n_vec      = 0;
      n_miss     = 0;
      iwnRst     = 1'b0;
      iwFlush    = 1'b0;
      iwInValid  = 1'b0;
      iwInstr    = 32'h0;
      iwPc       = 32'h0;
      iwOutReady = 1'b1;

      // Reset state
      @(negedge iwClk);
      @(negedge iwClk);
      chk("rst_valid", 32'(m_valid), 32'd0);
      chk("rst_pc",    m_pc,         32'd0);
      chk("rst_wimm",  m_wimm,       32'd0);
      chk("rst_cnt",   32'(m_cnt),   32'd0);
      iwnRst = 1'b1;
      @(negedge iwClk);
      chk("post_rst_ready", 32'(m_in_ready), 32'd1);
      chk("post_rst_valid", 32'(m_valid),    32'd0);

      // addi x1,x0,5
      issue(32'h00500093, 32'h0000_0000);
      chk("addi_valid", 32'(m_valid), 32'd1);
      chk("addi_alu",   32'(m_alu),   32'd0);
      chk("addi_bsrc",  32'(m_bsrc),  32'd0);
      chk("addi_bimm",  m_bimm,       32'd5);
      chk("addi_rd",    32'(m_rd),    32'd1);
      chk("addi_wsrc",  32'(m_wsrc),  32'd0);
      chk("addi_exc",   32'(m_exc),   32'd0);

      // mul x3,x1,x2 with and without M
      issue(32'h022081B3, 32'h0000_0004);
      chk("mul_alu",     32'(m_alu),  32'd16);
      chk("mul_rd",      32'(m_rd),   32'd3);
      chk("mul_bsrc",    32'(m_bsrc), 32'd1);
      chk("mul_exc",     32'(m_exc),  32'd0);
      chk("nom_mul_exc", 32'(n_exc),  32'd1);
      chk("nom_mul_rd",  32'(n_rd),   32'd0);
      chk("nom_mul_alu", 32'(n_alu),  32'd0);
      @(negedge iwClk);
      chk("nom_mul_cnt", 32'(n_cnt),   32'd1);
      chk("m_mul_cnt",   32'(m_cnt),   32'd0);
      chk("idle_valid",  32'(m_valid), 32'd0);

      // Immediate/PC-relative writebacks
      issue(32'h123452B7, 32'h0000_0008);
      chk("lui_wimm", m_wimm,       32'h1234_5000);
      chk("lui_wsrc", 32'(m_wsrc),  32'd2);
      chk("lui_rd",   32'(m_rd),    32'd5);
      issue(32'h00001317, 32'h0000_0100);
      chk("auipc_wimm", m_wimm,     32'h0000_1100);
      chk("auipc_rd",   32'(m_rd),  32'd6);
      issue(32'h008000EF, 32'h0000_0200);
      chk("jal_wimm",  m_wimm,       32'h0000_0204);
      chk("jal_npc",   32'(m_npc),   32'd1);
      chk("jal_rd",    32'(m_rd),    32'd1);
      chk("jal_imm20", 32'(m_imm20), 32'h0_0800);
      issue(32'h008000EF, 32'hFFFF_FFFC);
      chk("jal_wrap_wimm", m_wimm, 32'h0000_0000);

      // Memory, branch, system, bad shift
      issue(32'h0020A423, 32'h0000_0010);
      chk("sw_dwr",  32'(m_dwr), 32'd1);
      chk("sw_acc",  32'(m_acc), 32'd3);
      chk("sw_bimm", m_bimm,     32'd8);
      chk("sw_rd",   32'(m_rd),  32'd0);
      chk("sw_rs2",  32'(m_rs2), 32'd2);
      issue(32'hFFF08203, 32'h0000_0014);
      chk("lb_bimm", m_bimm,       32'hFFFF_FFFF);
      chk("lb_sext", 32'(m_sext),  32'd1);
      chk("lb_acc",  32'(m_acc),   32'd1);
      chk("lb_wsrc", 32'(m_wsrc),  32'd1);
      chk("lb_rd",   32'(m_rd),    32'd4);
      issue(32'h0000A203, 32'h0000_0018);
      chk("lw_sext", 32'(m_sext), 32'd0);
      chk("lw_acc",  32'(m_acc),  32'd3);
      issue(32'h00209463, 32'h0000_001C);
      chk("bne_alu",   32'(m_alu),   32'd10);
      chk("bne_inv",   32'(m_binv),  32'd1);
      chk("bne_bsrc",  32'(m_bsrc),  32'd1);
      chk("bne_npc",   32'(m_npc),   32'd3);
      chk("bne_imm12", 32'(m_imm12), 32'h008);
      chk("bne_rd",    32'(m_rd),    32'd0);
      issue(32'h00000073, 32'h0000_0020);
      chk("ecall_exc", 32'(m_exc), 32'd2);
      chk("ecall_rd",  32'(m_rd),  32'd0);
      issue(32'h40109093, 32'h0000_0024);
      chk("slli_bad_exc", 32'(m_exc), 32'd1);
      chk("slli_bad_rd",  32'(m_rd),  32'd0);
      @(negedge iwClk);
      chk("slli_cnt_m",   32'(m_cnt), 32'd1);
      chk("slli_cnt_nom", 32'(n_cnt), 32'd2);

      // Stall: third instruction held off until the skid drains
      iwOutReady = 1'b0;
      iwInValid  = 1'b1;
      iwInstr    = 32'h00500093;
      iwPc       = 32'h0000_0300;
      @(negedge iwClk);
      chk("stall_first_pc", m_pc,             32'h0000_0300);
      chk("stall_rdy1",     32'(m_in_ready),  32'd1);
      iwInstr = 32'h00700113;
      iwPc    = 32'h0000_0304;
      @(negedge iwClk);
      chk("stall_rdy2",   32'(m_in_ready), 32'd0);
      chk("stall_hold1",  m_pc,            32'h0000_0300);
      iwInstr = 32'h00900193;
      iwPc    = 32'h0000_0308;
      @(negedge iwClk);
      chk("stall_rdy3",   32'(m_in_ready), 32'd0);
      chk("stall_hold2",  m_pc,            32'h0000_0300);
      chk("stall_hold_rd", 32'(m_rd),      32'd1);
      iwOutReady = 1'b1;
      @(negedge iwClk);
      chk("drain_pc2",  m_pc,            32'h0000_0304);
      chk("drain_rd2",  32'(m_rd),       32'd2);
      chk("drain_rdy",  32'(m_in_ready), 32'd1);
      @(negedge iwClk);
      iwInValid = 1'b0;
      chk("drain_pc3",  m_pc,      32'h0000_0308);
      chk("drain_rd3",  32'(m_rd), 32'd3);
      @(negedge iwClk);
      chk("drain_empty", 32'(m_valid), 32'd0);

      // Flush with skid full, using an illegal RV64 ld in the output register
      iwOutReady = 1'b0;
      issue(32'h00003083, 32'h0000_0400);
      chk("ld_exc",  32'(m_exc),  32'd1);
      chk("ld_acc",  32'(m_acc),  32'd0);
      chk("ld_sext", 32'(m_sext), 32'd0);
      chk("ld_rd",   32'(m_rd),   32'd0);
      iwInValid = 1'b1;
      iwInstr   = 32'h00700113;
      iwPc      = 32'h0000_0404;
      @(negedge iwClk);
      chk("flush_pre_rdy", 32'(m_in_ready), 32'd0);
      iwFlush = 1'b1;
      iwInstr = 32'h00900193;
      iwPc    = 32'h0000_0408;
      @(negedge iwClk);
      iwFlush   = 1'b0;
      iwInValid = 1'b0;
      chk("flush_valid", 32'(m_valid),    32'd0);
      chk("flush_rdy",   32'(m_in_ready), 32'd1);
      chk("flush_cnt_m", 32'(m_cnt),      32'd1);
      iwOutReady = 1'b1;
      @(negedge iwClk);
      chk("flush_stays_empty", 32'(m_valid), 32'd0);
      chk("flush_cnt_nom",     32'(n_cnt),   32'd2);

      // Counter saturation on the 2-bit instance
      issue(32'hFFFF_FFFF, 32'h0000_0500);
      chk("unk_exc", 32'(m_exc), 32'd1);
      issue(32'hFFFF_FFFF, 32'h0000_0504);
      issue(32'hFFFF_FFFF, 32'h0000_0508);
      @(negedge iwClk);
      chk("sat_cnt_m",   32'(m_cnt), 32'd4);
      chk("sat_cnt_nom", 32'(n_cnt), 32'd3);

      // Async reset between edges with skid full
      iwOutReady = 1'b0;
      issue(32'h123452B7, 32'h0000_0600);
      iwInValid = 1'b1;
      iwInstr   = 32'h00001317;
      iwPc      = 32'h0000_0604;
      @(negedge iwClk);
      iwInValid = 1'b0;
      chk("arst_pre_rdy", 32'(m_in_ready), 32'd0);
      #2;
      iwnRst = 1'b0;
      #1;
      chk("arst_valid", 32'(m_valid), 32'd0);
      chk("arst_pc",    m_pc,         32'd0);
      chk("arst_wimm",  m_wimm,       32'd0);
      chk("arst_rd",    32'(m_rd),    32'd0);
      chk("arst_cnt_m", 32'(m_cnt),   32'd0);
      chk("arst_cnt_n", 32'(n_cnt),   32'd0);
      @(negedge iwClk);
      iwnRst     = 1'b1;
      iwOutReady = 1'b1;
      @(negedge iwClk);
      chk("arst_post_rdy",   32'(m_in_ready), 32'd1);
      chk("arst_post_valid", 32'(m_valid),    32'd0);
      issue(32'h00500093, 32'h0000_0700);
      chk("arst_resume_pc", m_pc, 32'h0000_0700);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
